// File: rtl/aes_req_arbiter_pkg.sv
// Shared types and constants for the AES request arbiter slice.
package aes_ctrl_pkg;

  localparam int unsigned AES_BLK_W = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } aes_arb_state_e;

  // Requester index width, never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/aes_req_arbiter_if.sv
// Requester, response and core-side signals of aes_req_arbiter bundled as one interface.
interface aes_req_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  import aes_ctrl_pkg::*;

  localparam int unsigned ID_W = id_width(NUM_REQ);

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ*AES_BLK_W-1:0] req_key;
  logic [NUM_REQ*AES_BLK_W-1:0] req_text;

  logic                         rsp_valid;
  logic                         rsp_ready;
  logic [ID_W-1:0]              rsp_id;
  logic [AES_BLK_W-1:0]         rsp_data;
  logic                         rsp_err;
  logic                         busy;

  logic                         core_ld;
  logic [AES_BLK_W-1:0]         core_key;
  logic [AES_BLK_W-1:0]         core_text_in;
  logic [AES_BLK_W-1:0]         core_text_out;
  logic                         core_done;

  modport slave (
    input  req_valid, req_key, req_text, rsp_ready, core_text_out, core_done,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, busy,
           core_ld, core_key, core_text_in
  );

  modport master (
    output req_valid, req_key, req_text, rsp_ready, core_text_out, core_done,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, busy,
           core_ld, core_key, core_text_in
  );

endinterface

// File: rtl/aes_req_arbiter_rr_picker.sv
// Combinational round-robin picker: first valid bit at or above ptr, wrapping to 0.
module aes_rr_picker #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = 2
) (
  input  logic [N-1:0]   valid_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [N-1:0]   gnt_oh_o,
  output logic [IDW-1:0] gnt_idx_o,
  output logic           any_o
);

  int unsigned idx;

  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    idx       = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = int'(ptr_i) + k;
      if (idx >= N) idx = idx - N;
      if (!any_o && valid_i[idx]) begin
        any_o         = 1'b1;
        gnt_oh_o[idx] = 1'b1;
        gnt_idx_o     = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/aes_req_arbiter.sv
// Round-robin front end sharing one AES core between NUM_REQ requesters.
// Optional watchdog on the core ld->done interval: define AES_ARB_TIMEOUT_EN.
module aes_req_arbiter
  import aes_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  aes_req_arbiter_if.slave bus
);

  localparam int unsigned ID_W = id_width(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_bad_cfg
    $error("aes_req_arbiter: illegal NUM_REQ or TIMEOUT");
  end

  aes_arb_state_e       state_q, state_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic [AES_BLK_W-1:0] key_q, key_d;
  logic [AES_BLK_W-1:0] text_q, text_d;
  logic [AES_BLK_W-1:0] data_q, data_d;

  logic [NUM_REQ-1:0]   gnt_oh;
  logic [ID_W-1:0]      gnt_idx;
  logic                 gnt_any;
  logic [NUM_REQ-1:0]   req_ready;

`ifdef AES_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  aes_rr_picker #(
    .N   (NUM_REQ),
    .IDW (ID_W)
  ) u_picker (
    .valid_i   (bus.req_valid),
    .ptr_i     (ptr_q),
    .gnt_oh_o  (gnt_oh),
    .gnt_idx_o (gnt_idx),
    .any_o     (gnt_any)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      key_q   <= '0;
      text_q  <= '0;
      data_q  <= '0;
`ifdef AES_ARB_TIMEOUT_EN
      err_q   <= 1'b0;
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      key_q   <= key_d;
      text_q  <= text_d;
      data_q  <= data_d;
`ifdef AES_ARB_TIMEOUT_EN
      err_q   <= err_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    key_d     = key_q;
    text_d    = text_q;
    data_d    = data_q;
    req_ready = '0;
`ifdef AES_ARB_TIMEOUT_EN
    err_d     = err_q;
    cnt_d     = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          req_ready = gnt_oh;
          id_d      = gnt_idx;
          for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt_oh[i]) begin
              key_d  = bus.req_key[i*AES_BLK_W +: AES_BLK_W];
              text_d = bus.req_text[i*AES_BLK_W +: AES_BLK_W];
            end
          end
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
`ifdef AES_ARB_TIMEOUT_EN
        cnt_d = '0;
`endif
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.core_done) begin
          data_d  = bus.core_text_out;
`ifdef AES_ARB_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = RESP;
        end
`ifdef AES_ARB_TIMEOUT_EN
        // Compare against TIMEOUT-1 so RESP is entered exactly TIMEOUT WAIT cycles in.
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RESP: begin
        if (bus.rsp_ready) begin
          ptr_d   = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready    = req_ready;
  assign bus.rsp_valid    = (state_q == RESP);
  assign bus.rsp_id       = id_q;
  assign bus.rsp_data     = data_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.core_ld      = (state_q == LAUNCH);
  assign bus.core_key     = key_q;
  assign bus.core_text_in = text_q;
`ifdef AES_ARB_TIMEOUT_EN
  assign bus.rsp_err      = err_q;
`else
  assign bus.rsp_err      = 1'b0;
`endif

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Directed bench for aes_req_arbiter with a lookup-table stand-in for the AES core.
module tb_aes_req_arbiter;

  localparam int unsigned NREQ   = 4;
  localparam int unsigned CORE_L = 6;
`ifdef AES_ARB_TIMEOUT_EN
  localparam int unsigned TO = 16;
`else
  localparam int unsigned TO = 64;
`endif

  localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P1 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] C1 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] K2 = 128'h0;
  localparam logic [127:0] P2 = {64'h1111111111111111, 64'h2222222222222222};
  localparam logic [127:0] C2 = {64'h2222222222222222, 64'h1111111111111111};
  localparam logic [127:0] K3 = {128{1'b1}};
  localparam logic [127:0] P3 = 128'h0;
  localparam logic [127:0] C3 = {128{1'b1}};

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  aes_req_arbiter_if #(.NUM_REQ(NREQ)) bus ();

  aes_req_arbiter #(.NUM_REQ(NREQ), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Core stand-in: the two FIPS-197 / SP800-38A vectors, otherwise key ^ half-swapped text.
  function automatic logic [127:0] ref_cipher(input logic [127:0] k, input logic [127:0] t);
    if (k == K0 && t == P0) return C0;
    if (k == K1 && t == P1) return C1;
    return k ^ {t[63:0], t[127:64]};
  endfunction

  logic [3:0]   m_cnt;
  logic [127:0] m_key, m_txt, m_out;
  logic         m_done;
  bit           core_en = 1'b1;
  bit           stray   = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cnt <= '0; m_key <= '0; m_txt <= '0; m_out <= '0; m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (bus.core_ld) begin
        m_cnt <= 4'(CORE_L);
        m_key <= bus.core_key;
        m_txt <= bus.core_text_in;
      end else if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1'b1;
        if (m_cnt == 1 && core_en) begin
          m_done <= 1'b1;
          m_out  <= ref_cipher(m_key, m_txt);
        end
      end
      if (stray) m_done <= 1'b1;
    end
  end

  assign bus.core_done     = m_done;
  assign bus.core_text_out = m_out;

  for (genvar g = 0; g < NREQ; g++) begin : g_proto
    assert property (@(posedge clk) disable iff (!rst)
      (bus.req_valid[g] && !bus.req_ready[g]) |=> bus.req_valid[g]);
  end

  int total = 0;
  int bad   = 0;
  logic [3:0] pend = '0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    pend = '0;
    bus.req_valid = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  // Accept in an IDLE cycle, then step into LAUNCH.
  task automatic do_accept(input int unsigned id, input bit keep);
    logic [3:0] oh;
    oh = 4'd1 << id;
    @(negedge clk);
    bus.req_valid = pend;
    #1;
    check("accept_ready", 128'(bus.req_ready), 128'(oh));
    check("idle_busy", 128'(bus.busy), 128'(0));
    check("idle_rsp_valid", 128'(bus.rsp_valid), 128'(0));
    @(negedge clk);
    if (!keep) pend = pend & ~oh;
    bus.req_valid = pend;
    #1;
    check("launch_ld", 128'(bus.core_ld), 128'(1));
    check("launch_ready", 128'(bus.req_ready), 128'(0));
  endtask

  task automatic wait_done();
    int cyc = 0;
    int extra_ld = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (bus.core_ld) extra_ld++;
    end while (!bus.core_done && cyc < 100);
    check("ld_single_pulse", 128'(extra_ld), 128'(0));
    check("done_seen", 128'(bus.core_done), 128'(1));
  endtask

  task automatic check_resp(input int unsigned id, input logic [127:0] data);
    @(negedge clk);
    check("rsp_valid", 128'(bus.rsp_valid), 128'(1));
    check("rsp_id", 128'(bus.rsp_id), 128'(id));
    check("rsp_data", bus.rsp_data, data);
    check("rsp_err", 128'(bus.rsp_err), 128'(0));
  endtask

  task automatic run_job(input logic [3:0] add, input int unsigned id,
                         input logic [127:0] data, input bit keep);
    pend = pend | add;
    do_accept(id, keep);
    wait_done();
    check_resp(id, data);
  endtask

  typedef struct {
    logic [3:0]   add;
    int unsigned  exp_id;
    logic [127:0] exp_data;
  } vec_t;

  vec_t vt [11];

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int viol;
    logic [127:0] held;

    vt[0]  = '{4'b0001, 0, C0};
    vt[1]  = '{4'b1001, 3, C3};
    vt[2]  = '{4'b0100, 0, C0};
    vt[3]  = '{4'b0010, 1, C1};
    vt[4]  = '{4'b1000, 2, C2};
    vt[5]  = '{4'b0001, 3, C3};
    vt[6]  = '{4'b0000, 0, C0};
    vt[7]  = '{4'b1111, 1, C1};
    vt[8]  = '{4'b0000, 2, C2};
    vt[9]  = '{4'b0000, 3, C3};
    vt[10] = '{4'b0000, 0, C0};

    bus.req_valid = '0;
    bus.req_key   = {K3, K2, K1, K0};
    bus.req_text  = {P3, P2, P1, P0};
    bus.rsp_ready = 1'b1;

    // Reset state
    do_reset();
    #1;
    check("rst_rsp_valid", 128'(bus.rsp_valid), 128'(0));
    check("rst_busy", 128'(bus.busy), 128'(0));
    check("rst_ld", 128'(bus.core_ld), 128'(0));
    check("rst_rsp_data", bus.rsp_data, 128'(0));
    check("rst_core_key", bus.core_key, 128'(0));

    // Table: pending set accumulates, grants follow the rotating pointer
    for (int i = 0; i < 11; i++) run_job(vt[i].add, vt[i].exp_id, vt[i].exp_data, 1'b0);

    // All four valid from reset: strict 0,1,2,3
    do_reset();
    run_job(4'b1111, 0, C0, 1'b0);
    run_job(4'b0000, 1, C1, 1'b0);
    run_job(4'b0000, 2, C2, 1'b0);
    run_job(4'b0000, 3, C3, 1'b0);

    // Requesters 1 and 3 always valid: 1,3,1,3 with the pointer wrapping after 3
    do_reset();
    pend = 4'b1010;
    run_job(4'b0000, 1, C1, 1'b1);
    run_job(4'b0000, 3, C3, 1'b1);
    run_job(4'b0000, 1, C1, 1'b1);
    run_job(4'b0000, 3, C3, 1'b1);

    // Response back-pressure for 10 cycles with another requester waiting
    do_reset();
    bus.rsp_ready = 1'b0;
    run_job(4'b0100, 2, C2, 1'b0);
    pend = pend | 4'b0001;
    bus.req_valid = pend;
    held = bus.rsp_data;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      check("hold_valid", 128'(bus.rsp_valid), 128'(1));
      check("hold_id", 128'(bus.rsp_id), 128'(2));
      check("hold_data", bus.rsp_data, held);
      check("hold_ready", 128'(bus.req_ready), 128'(0));
      check("hold_ld", 128'(bus.core_ld), 128'(0));
    end
    bus.rsp_ready = 1'b1;
    run_job(4'b0000, 0, C0, 1'b0);

    // Reset three cycles into WAIT after moving the pointer away from 0
    do_reset();
    run_job(4'b0100, 2, C2, 1'b0);
    pend = 4'b0010;
    do_accept(1, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_outputs",
          128'({bus.rsp_valid, bus.rsp_err, bus.busy, bus.core_ld, bus.req_ready}), 128'(0));
    check("mid_rst_rsp_id", 128'(bus.rsp_id), 128'(0));
    check("mid_rst_rsp_data", bus.rsp_data, 128'(0));
    check("mid_rst_core_key", bus.core_key, 128'(0));
    check("mid_rst_core_text", bus.core_text_in, 128'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    viol = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.rsp_valid || bus.busy) viol++;
    end
    check("no_rsp_after_rst", 128'(viol), 128'(0));
    run_job(4'b1001, 0, C0, 1'b0);
    run_job(4'b0000, 3, C3, 1'b0);

`ifdef AES_ARB_TIMEOUT_EN
    // Core never answers: error response TIMEOUT+1 cycles after ld
    do_reset();
    core_en = 1'b0;
    pend = 4'b0001;
    do_accept(0, 1'b0);
    viol = 0;
    do begin
      @(negedge clk);
      viol++;
    end while (!bus.rsp_valid && viol < 100);
    check("to_latency", 128'(viol), 128'(TO + 1));
    check("to_err", 128'(bus.rsp_err), 128'(1));
    check("to_data", bus.rsp_data, 128'(0));
    check("to_id", 128'(bus.rsp_id), 128'(0));
    core_en = 1'b1;
`endif

    // Stray core_done while idle must not produce a response
    @(negedge clk);
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    viol = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.rsp_valid || bus.busy) viol++;
    end
    check("stray_done_ignored", 128'(viol), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_req_arbiter.md
# aes_req_arbiter

Round-robin scheduler that shares one `aes_cipher_top` encryption core between `NUM_REQ` requesters. It accepts one job (key, plaintext) at a time through per-requester valid/ready handshakes. It sequences the core's `ld`/`done` protocol and returns the ciphertext on a single tagged response channel. It sits directly in front of the core, and the core is instantiated beside it, not inside it.

## Interface
- `NUM_REQ`, 4 — number of requesters, legal 2..8
- `TIMEOUT`, 64 — watchdog limit in cycles, core `ld` to `done`; used only with `AES_ARB_TIMEOUT_EN`
- `clk`  in  1  — single clock, all logic rising-edge
- `rst`  in  1  — reset, asynchronous, active-low
- `req_valid`  in  NUM_REQ  — requester i has a job
- `req_ready`  out  NUM_REQ  — one-hot accept pulse
- `req_key`  in  NUM_REQ*128  — key of requester i at bits [128i+127:128i]
- `req_text`  in  NUM_REQ*128  — plaintext, packed the same way
- `rsp_valid`  out  1  — response available
- `rsp_ready`  in  1  — consumer accepts response
- `rsp_id`  out  max(1,$clog2(NUM_REQ))  — index of the requester served
- `rsp_data`  out  128  — ciphertext
- `rsp_err`  out  1  — watchdog expired; data invalid
- `busy`  out  1  — state != IDLE
- `core_ld`  out  1  — to core `ld`
- `core_key`  out  128  — to core `key`
- `core_text_in`  out  128  — to core `text_in`
- `core_text_out`  in  128  — from core `text_out`
- `core_done`  in  1  — from core `done`, one-cycle pulse

## Operation
- FSM states and transitions:
  - IDLE → LAUNCH: any `req_valid` set. Grant = first set bit searching upward from `ptr`, wrapping from NUM_REQ-1 to 0. `req_ready[grant]`=1 combinationally this cycle. Latch key, text and id.
  - LAUNCH → WAIT: `core_ld`=1 for exactly this cycle. `core_key`/`core_text_in` driven from the latches, which hold until the next acceptance.
  - WAIT → RESP: on `core_done`, register `core_text_out` into `rsp_data`, set `rsp_err`=0.
  - RESP → IDLE: `rsp_valid`=1, held with stable `rsp_id`/`rsp_data`/`rsp_err` until `rsp_valid && rsp_ready`. Then `ptr` ← grant+1 mod NUM_REQ.
- `req_ready` is 0 outside IDLE. No new job is accepted while a response is pending.
- `core_done` outside WAIT is ignored.
- Requesters must hold `req_valid`, key and text stable until `req_ready`. Dropping `req_valid` early is a protocol violation, and the bench asserts on it.
- Reset (`rst`=0, any state, including mid-WAIT): state IDLE, `ptr`=0, and `req_ready`, `rsp_valid`, `rsp_err`, `busy`, `core_ld` all 0. `rsp_id`, `rsp_data`, `core_key` and `core_text_in` are 0. The in-flight job is dropped and no response is produced. The system resets the core on the same `rst`.

## Timing
- Accept at cycle T. `core_ld` at T+1. Core `done` at T+1+L, where L is the core latency. `rsp_valid` at T+2+L.
- With `rsp_ready` held high, RESP lasts 1 cycle and the next accept can occur at T+3+L.
- Job-to-job overhead beyond the core latency is 3 cycles.
- `req_ready` depends combinationally on `req_valid`, `state` and `ptr`. All other outputs are registered.

## Configuration
- `AES_ARB_TIMEOUT_EN` defined:
  - A counter clears on entering WAIT and increments each WAIT cycle.
  - If it reaches `TIMEOUT` without `core_done`, go to RESP with `rsp_err`=1 and `rsp_data`=0.
  - A late `core_done` is ignored.
- `AES_ARB_TIMEOUT_EN` undefined: no counter. `rsp_err` is tied 0. WAIT exits only on `core_done`. Ports are unchanged.

## Structure
- Package `aes_ctrl_pkg` holds:
  - the FSM state enum (IDLE, LAUNCH, WAIT, RESP)
  - `AES_BLK_W`=128
  - an id-width function max(1,$clog2(n))
- One sub-module `aes_rr_picker`: combinational round-robin priority picker. Inputs are the valid vector and `ptr`. Outputs are a one-hot grant, the grant index and an any-valid flag.

## Test plan
- Single job: requester 0, key 000102030405060708090a0b0c0d0e0f, text 00112233445566778899aabbccddeeff → `rsp_id`=0 and `rsp_data`=69c4e0d86a7b0430d8cdb78070b4c55a. `core_ld` is a single pulse one cycle after accept, and `rsp_valid` comes one cycle after `core_done`.
- All four requesters valid from reset, requester 1 using key 2b7e151628aed2a6abf7158809cf4f3c with text 6bc1bee22e409f96e93d7e117393172a → grants in order 0,1,2,3. Requester 1's response is 3ad77bb40d7a3660a89ecaf32466ef97.
- Requesters 1 and 3 re-assert continuously → service order 1,3,1,3. `ptr` wraps 3→0 after each grant of requester 3.
- `rsp_ready` held low for 10 cycles in RESP → `rsp_valid` stays 1, `rsp_data`/`rsp_id` are stable, `req_ready`=0 and `core_ld`=0 throughout.
- `rst` asserted 3 cycles into WAIT → all outputs 0 immediately and no response. After release, a new job returns the correct ciphertext and is granted from `ptr`=0.
- `AES_ARB_TIMEOUT_EN` defined, `TIMEOUT`=16, core model never raises done → `rsp_err`=1 and `rsp_data`=0 with `rsp_valid` at ld+17. A subsequent stray `core_done` causes no response.
